myproject_sdiv_seq_21s_6s_16: RTL and testbench
===============================================

Name: myproject_sdiv_seq_21s_6s_16

Overview:
- Sequential signed divider; the inverse of the 6s x 16s -> 21 multiply used in the dense/conv layers.
- Recovers a 16-bit quotient and 6-bit remainder from a 21-bit product-domain value and a 6-bit weight, e.g. for normalisation and pool averaging.
- Radix-2 restoring iteration, one quotient bit per enabled cycle.
- HLS-style ce/start/done handshake so it can be dropped into generated dataflow.

Parameters:
- DIVIDEND_W, 21, dividend width (signed)
- DIVISOR_W, 6, divisor width (signed)
- QUOT_W, 16, quotient output width (signed, saturating)

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  asynchronous active-high reset
- ce  in  1  clock enable; when low, all state and outputs hold
- start  in  1  request; sampled only in IDLE with ce=1
- din0  in  DIVIDEND_W  dividend, signed
- din1  in  DIVISOR_W  divisor, signed
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse; results valid from this cycle
- quotient  out  QUOT_W  signed quotient, held until next done
- remainder  out  DIVISOR_W  signed remainder, held until next done
- ovf  out  1  quotient saturated; held with results
- dz  out  1  divide by zero; held with results

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, ovf, dz = 0; quotient and remainder = 0.
- Semantics: C truncation toward zero. Remainder sign follows the dividend; |remainder| < |divisor|.
- States:
  - IDLE: on start & ce, latch |din0| (DIVIDEND_W bits unsigned), |din1| (DIVISOR_W bits unsigned) and both signs; clear iteration count; go to CALC.
  - CALC: each ce cycle, shift the partial remainder (DIVISOR_W+1 bits) left by one dividend bit, trial-subtract the divisor magnitude, and record a quotient bit (DIVIDEND_W-bit magnitude). After DIVIDEND_W iterations go to FIX.
  - FIX: apply signs, saturate, register the outputs, pulse done, go to IDLE.
- Latency: start accepted at edge k -> done high in the cycle after edge k+DIVIDEND_W+1 (23 clocks for defaults), plus one clock per ce-low cycle.
- Throughput: a new start may be accepted in the cycle done is high (back-to-back issue).
- Saturation: the signed quotient is clamped to [-2^15, 2^15-1]. ovf=1 if clamped.
  - -1048576 / -1 -> 32767, ovf=1.
  - -32768 exactly is not overflow.
- Divide by zero (din1=0): quotient = 32767 if dividend >= 0, else -32768; remainder=0; dz=1; ovf=0. Iteration still runs the full latency unless the macro below is set.
- Boundaries:
  - start while busy is ignored (no queuing).
  - din0/din1 are don't-care outside accept.
  - ce low in IDLE: start ignored.
  - ce low in FIX: done is delayed; it stays a single pulse.
  - Reset mid-CALC aborts with no done.
  - Most negative divisor -32: magnitude 32 handled by the 7-bit partial remainder.

Optional Feature:
- Macro: MYPROJECT_SDIV_EARLY_DZ_EN.
- Defined: divisor zero detected at accept goes straight to FIX; done appears 2 clocks after accept, with dz results as above.
- Undefined: divisor zero takes the full fixed latency, and latency is data-independent.

Decomposition:
- Package myproject_div_pkg holds:
  - state enum (IDLE, CALC, FIX)
  - QUOT_MAX/QUOT_MIN constants
  - iteration counter width $clog2(DIVIDEND_W+1)
- One sub-module, myproject_sdiv_seq_core: unsigned restoring iteration (partial remainder, quotient shift register, counter).
- Top level owns sign handling, saturation, FSM and handshake.

Test Plan:
- 1000 / 7 -> quotient=142, remainder=6, ovf=0, dz=0; done exactly 23 clocks after accept.
- -1000 / 7 -> -142, -6. 1000 / -32 -> -31, 8. -1000 / -32 -> 31, -8.
- Saturation:
  - 1048575 / 1 -> 32767, ovf=1.
  - -1048576 / 1 -> -32768, ovf=1.
  - -32768 / 1 -> -32768, ovf=0.
- 5 / 0 -> 32767, remainder 0, dz=1 at 23 clocks (2 clocks with MYPROJECT_SDIV_EARLY_DZ_EN); -5 / 0 -> -32768, dz=1.
- Drop ce for 5 cycles mid-CALC -> done at 28 clocks with correct result; a second start while busy is ignored; back-to-back start on the done cycle is accepted.
- Assert ap_rst asynchronously mid-CALC -> all outputs 0 immediately, no done; the next start completes normally.

Source files
------------

// File: rtl/myproject_div_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
// Widths match the 6s x 16s -> 21 multiply this divider inverts.
package myproject_div_pkg;

    localparam int DIVIDEND_W = 21;
    localparam int DIVISOR_W  = 6;
    localparam int QUOT_W     = 16;
    localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

    localparam logic [QUOT_W-1:0] QUOT_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] QUOT_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    function automatic logic [DIVIDEND_W-1:0] mag_a(input logic [DIVIDEND_W-1:0] v);
        return v[DIVIDEND_W-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DIVISOR_W-1:0] mag_b(input logic [DIVISOR_W-1:0] v);
        return v[DIVISOR_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/myproject_sdiv_seq_core.sv
// Unsigned radix-2 restoring divider datapath: one quotient bit per step.
// Quotient bits shift in behind the dividend bits as they are consumed.
module myproject_sdiv_seq_core
    import myproject_div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [DIVIDEND_W-1:0] a,
    input  logic [DIVISOR_W-1:0]  b,
    output logic [DIVIDEND_W-1:0] qmag,
    output logic [DIVISOR_W-1:0]  rmag,
    output logic                  last
);

    logic [DIVISOR_W:0]    rem_q;
    logic [DIVIDEND_W-1:0] sh_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W+1:0]  diff;
    logic                  fits;

    // remainder stays below 32, so the shifted value never exceeds 7 bits
    assign trial = (rem_q << 1) | (DIVISOR_W+1)'(sh_q[DIVIDEND_W-1]);
    assign diff  = {1'b0, trial} - {2'b00, dvs_q};
    assign fits  = ~diff[DIVISOR_W+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            sh_q  <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            sh_q  <= a;
            dvs_q <= b;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= fits ? diff[DIVISOR_W:0] : trial;
            sh_q  <= {sh_q[DIVIDEND_W-2:0], fits};
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign qmag = sh_q;
    assign rmag = rem_q[DIVISOR_W-1:0];
    assign last = (cnt_q == CNT_W'(DIVIDEND_W - 1));

endmodule

// File: rtl/myproject_sdiv_seq_21s_6s_16.sv
// Sequential signed divider 21s / 6s -> 16s quotient, 6s remainder, ce/start/done.
// Define MYPROJECT_SDIV_EARLY_DZ_EN to short-cut divide-by-zero straight to FIX.
module myproject_sdiv_seq_21s_6s_16
    import myproject_div_pkg::*;
(
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  busy,
    output logic                  done,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  ovf,
    output logic                  dz
);

    state_t state_q, state_d;

    logic accept, step, fix;
    logic sign0_q, sign1_q, zero_q;

    logic [DIVIDEND_W-1:0] qmag;
    logic [DIVISOR_W-1:0]  rmag;
    logic                  last;

    logic [DIVIDEND_W:0]  qext, qs;
    logic                 fit;
    logic [QUOT_W-1:0]    q_fix;
    logic [DIVISOR_W-1:0] r_fix;
    logic                 ovf_fix, dz_fix;

    myproject_sdiv_seq_core u_core (
        .clk  (ap_clk),
        .rst  (ap_rst),
        .load (accept),
        .step (step),
        .a    (mag_a(din0)),
        .b    (mag_b(din1)),
        .qmag (qmag),
        .rmag (rmag),
        .last (last)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ce && start) begin
                    accept = 1'b1;
`ifdef MYPROJECT_SDIV_EARLY_DZ_EN
                    state_d = (din1 == '0) ? FIX : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                if (ce) begin
                    step = 1'b1;
                    if (last) state_d = FIX;
                end
            end
            FIX: begin
                if (ce) begin
                    fix     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // quotient fits QUOT_W bits iff all bits above the sign bit match it
    assign qext = {1'b0, qmag};
    assign qs   = (sign0_q ^ sign1_q) ? (~qext + 1'b1) : qext;
    assign fit  = (&qs[DIVIDEND_W:QUOT_W-1]) | ~(|qs[DIVIDEND_W:QUOT_W-1]);

    always_comb begin
        q_fix   = fit ? qs[QUOT_W-1:0] : (qs[DIVIDEND_W] ? QUOT_MIN : QUOT_MAX);
        r_fix   = sign0_q ? (~rmag + 1'b1) : rmag;
        ovf_fix = ~fit;
        dz_fix  = 1'b0;
        if (zero_q) begin
            q_fix   = sign0_q ? QUOT_MIN : QUOT_MAX;
            r_fix   = '0;
            ovf_fix = 1'b0;
            dz_fix  = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            sign0_q   <= 1'b0;
            sign1_q   <= 1'b0;
            zero_q    <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            done    <= fix;
            if (accept) begin
                sign0_q <= din0[DIVIDEND_W-1];
                sign1_q <= din1[DIVISOR_W-1];
                zero_q  <= (din1 == '0);
            end
            if (fix) begin
                quotient  <= q_fix;
                remainder <= r_fix;
                ovf       <= ovf_fix;
                dz        <= dz_fix;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_myproject_sdiv_seq_21s_6s_16.sv
// Directed + random checks of the sequential signed divider with a result scoreboard.
// Latency expectations follow MYPROJECT_SDIV_EARLY_DZ_EN for divide-by-zero.
module tb_myproject_sdiv_seq_21s_6s_16;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ce;
    logic        start;
    logic [20:0] din0;
    logic [5:0]  din1;
    logic        busy, done, ovf, dz;
    logic [15:0] quotient;
    logic [5:0]  remainder;

    int total = 0;
    int fails = 0;

`ifdef MYPROJECT_SDIV_EARLY_DZ_EN
    localparam int DZ_LAT = 2;
`else
    localparam int DZ_LAT = 23;
`endif
    localparam int LAT = 23;

    typedef struct {
        int q;
        int r;
        bit ovf;
        bit dz;
    } exp_t;

    exp_t sb[$];

    always #5 ap_clk = ~ap_clk;

    myproject_sdiv_seq_21s_6s_16 dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ce        (ce),
        .start     (start),
        .din0      (din0),
        .din1      (din1),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dz        (dz)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int q;
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        if (b == 0) begin
            e.q  = (a >= 0) ? 32767 : -32768;
            e.r  = 0;
            e.dz = 1'b1;
        end else begin
            q   = a / b;
            e.r = a % b;
            if (q > 32767) begin
                q = 32767;
                e.ovf = 1'b1;
            end else if (q < -32768) begin
                q = -32768;
                e.ovf = 1'b1;
            end
            e.q = q;
        end
        return e;
    endfunction

    function automatic exp_t mk(input int q, input int r, input bit o, input bit z);
        exp_t e;
        e.q = q;
        e.r = r;
        e.ovf = o;
        e.dz = z;
        return e;
    endfunction

    task automatic drive(input int a, input int b);
        @(negedge ap_clk);
        din0  = a[20:0];
        din1  = b[5:0];
        start = 1'b1;
        @(posedge ap_clk);
        #1 start = 1'b0;
    endtask

    task automatic issue(input int a, input int b, input exp_t e);
        sb.push_back(e);
        drive(a, b);
    endtask

    task automatic wait_done(input int gap_at, input int gap_len,
                             input int poke_at, output int lat);
        int n;
        n = 0;
        lat = -1;
        while (n < 200) begin
            ce = !(n >= gap_at && n < gap_at + gap_len);
            if (n == poke_at) begin
                din0  = 21'd99;
                din1  = 6'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge ap_clk);
            #1;
            n++;
            if (done) begin
                lat = n + 1;
                break;
            end
        end
        ce = 1'b1;
        start = 1'b0;
    endtask

    task automatic complete(input string tag, input int gap_at, input int gap_len,
                            input int poke_at, input int elat);
        int lat;
        exp_t e;
        e = mk(0, 0, 0, 0);
        wait_done(gap_at, gap_len, poke_at, lat);
        if (sb.size() != 0) e = sb.pop_front();
        chk({tag, " latency"}, lat, elat);
        chk({tag, " quotient"}, $signed(quotient), e.q);
        chk({tag, " remainder"}, $signed(remainder), e.r);
        chk({tag, " ovf"}, ovf, e.ovf);
        chk({tag, " dz"}, dz, e.dz);
    endtask

    task automatic pulse_gone(input string tag);
        @(posedge ap_clk);
        #1 chk({tag, " done pulse"}, done, 1'b0);
    endtask

    initial begin
        int seen;
        int a, b;
        logic [20:0] ra;
        logic [5:0]  rb;
        exp_t e;

        ap_rst = 1'b1;
        ce     = 1'b1;
        start  = 1'b0;
        din0   = '0;
        din1   = '0;
        @(negedge ap_clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset quotient", $signed(quotient), 0);
        chk("reset remainder", $signed(remainder), 0);
        chk("reset ovf", ovf, 1'b0);
        chk("reset dz", dz, 1'b0);
        ap_rst = 1'b0;

        issue(1000, 7, mk(142, 6, 0, 0));
        chk("busy after accept", busy, 1'b1);
        complete("1000/7", -1, 0, -1, LAT);
        pulse_gone("1000/7");

        issue(-1000, 7, mk(-142, -6, 0, 0));
        complete("-1000/7", -1, 0, -1, LAT);
        issue(1000, -32, mk(-31, 8, 0, 0));
        complete("1000/-32 busy start", -1, 0, 3, LAT);
        seen = 0;
        repeat (30) begin
            @(posedge ap_clk);
            #1 if (done) seen++;
        end
        chk("ignored start no done", seen, 0);

        issue(-1000, -32, mk(31, -8, 0, 0));
        complete("-1000/-32 ce low in FIX", 21, 3, -1, LAT + 3);
        pulse_gone("ce low in FIX");

        issue(1048575, 1, mk(32767, 0, 1, 0));
        complete("1048575/1", -1, 0, -1, LAT);
        issue(-1048576, 1, mk(-32768, 0, 1, 0));
        complete("-1048576/1", -1, 0, -1, LAT);
        issue(-32768, 1, mk(-32768, 0, 0, 0));
        complete("-32768/1", -1, 0, -1, LAT);
        issue(-1048576, -1, mk(32767, 0, 1, 0));
        complete("-1048576/-1", -1, 0, -1, LAT);

        issue(5, 0, mk(32767, 0, 0, 1));
        complete("5/0", -1, 0, -1, DZ_LAT);
        issue(-5, 0, mk(-32768, 0, 0, 1));
        complete("-5/0", -1, 0, -1, DZ_LAT);

        issue(1000, 7, mk(142, 6, 0, 0));
        complete("ce gap", 5, 5, -1, LAT + 5);
        issue(-777, 5, mk(-155, -2, 0, 0));
        complete("back-to-back", -1, 0, -1, LAT);

        @(negedge ap_clk);
        ce    = 1'b0;
        start = 1'b1;
        din0  = 21'd7;
        din1  = 6'd1;
        repeat (3) @(posedge ap_clk);
        #1 chk("ce low idle ignores start", busy, 1'b0);
        @(negedge ap_clk);
        start = 1'b0;
        ce    = 1'b1;

        drive(1000, 7);
        repeat (10) @(posedge ap_clk);
        #2 ap_rst = 1'b1;
        #1;
        chk("async rst quotient", $signed(quotient), 0);
        chk("async rst remainder", $signed(remainder), 0);
        chk("async rst busy", busy, 1'b0);
        chk("async rst ovf", ovf, 1'b0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge ap_clk);
            #1 if (done) seen++;
        end
        chk("aborted no done", seen, 0);
        issue(-1000, 7, mk(-142, -6, 0, 0));
        complete("after reset", -1, 0, -1, LAT);

        for (int i = 0; i < 6; i++) begin
            ra = 21'($urandom);
            rb = 6'($urandom);
            a = $signed(ra);
            b = $signed(rb);
            e = model(a, b);
            issue(a, b, e);
            complete($sformatf("rand%0d %0d/%0d", i, a, b), -1, 0, -1,
                     (b == 0) ? DZ_LAT : LAT);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
